// File: rtl/cache_pkg.sv
// cache_pkg
//  Shared definitions for the cache data array, its burst engine and the tag array.
//  - Default geometry constants (line index width, word offset width, word width).
//  - Burst engine state encoding.
//  - Helpers deriving words-per-line and byte-enable width from the geometry.
package cache_pkg;

  localparam int DEF_IDX_W      = 5;
  localparam int DEF_WORD_OFF_W = 2;
  localparam int DEF_DATA_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_EVICT = 2'd2
  } burst_state_e;

  // Number of words in a line for a given word-offset width.
  function automatic int words_of(input int word_off_w);
    return 1 << word_off_w;
  endfunction

  // Number of byte lanes in a word of the given width.
  function automatic int be_w_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/cache_burst_fsm.sv
// cache_burst_fsm
//  Burst engine for the cache data array. Refills a line from the memory side
//  (FILL) or streams a line back to it (EVICT), one word per handshake.
//  Ports:
//   iCLK, iRST      clock, synchronous active-high reset
//   fill_start      begin a refill of fill_idx (accepted only when idle)
//   fill_idx        refill target line, latched on acceptance
//   fill_valid      refill beat valid from memory side
//   evict_start     begin an eviction of evict_idx (wins over fill_start)
//   evict_idx       eviction source line, latched on acceptance
//   evict_ready     memory side accepts the current eviction beat
//   fill_ready      engine is in FILL and takes a beat each fill_valid cycle
//   fill_done       1-cycle pulse after the last refill beat
//   evict_valid     engine is in EVICT, a beat is presented
//   evict_done      1-cycle pulse after the last eviction beat
//   busy            engine not idle
//   fill_wr         write strobe for the array (refill beat accepted)
//   burst_addr      {line, beat} address used for both refill writes and eviction reads
module cache_burst_fsm
  import cache_pkg::*;
#(
  parameter int IDX_W      = DEF_IDX_W,
  parameter int WORD_OFF_W = DEF_WORD_OFF_W
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic                        fill_start,
  input  logic [IDX_W-1:0]            fill_idx,
  input  logic                        fill_valid,
  input  logic                        evict_start,
  input  logic [IDX_W-1:0]            evict_idx,
  input  logic                        evict_ready,
  output logic                        fill_ready,
  output logic                        fill_done,
  output logic                        evict_valid,
  output logic                        evict_done,
  output logic                        busy,
  output logic                        fill_wr,
  output logic [IDX_W+WORD_OFF_W-1:0] burst_addr
);

  localparam logic [WORD_OFF_W-1:0] LAST_BEAT = '1;
  localparam logic [WORD_OFF_W-1:0] BEAT_ONE  = WORD_OFF_W'(1);

  burst_state_e          r_state;
  logic [WORD_OFF_W-1:0] r_beat;
  logic [IDX_W-1:0]      r_line;
  logic                  r_fill_done;
  logic                  r_evict_done;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state      <= ST_IDLE;
      r_beat       <= '0;
      r_line       <= '0;
      r_fill_done  <= 1'b0;
      r_evict_done <= 1'b0;
    end else begin
      // Done flags are single-cycle pulses unless re-set below.
      r_fill_done  <= 1'b0;
      r_evict_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Eviction has priority; a simultaneous fill_start is dropped
          // and must be re-issued by the controller.
          if (evict_start) begin
            r_state <= ST_EVICT;
            r_line  <= evict_idx;
            r_beat  <= '0;
          end else if (fill_start) begin
            r_state <= ST_FILL;
            r_line  <= fill_idx;
            r_beat  <= '0;
          end
        end
        ST_FILL: begin
          if (fill_valid) begin
            // Beat counter wraps to zero on the last beat.
            r_beat <= r_beat + BEAT_ONE;
            if (r_beat == LAST_BEAT) begin
              r_state     <= ST_IDLE;
              r_fill_done <= 1'b1;
            end
          end
        end
        ST_EVICT: begin
          if (evict_ready) begin
            r_beat <= r_beat + BEAT_ONE;
            if (r_beat == LAST_BEAT) begin
              r_state      <= ST_IDLE;
              r_evict_done <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_beat  <= '0;
        end
      endcase
    end
  end

  logic w_in_fill;
  logic w_in_evict;

  assign w_in_fill   = (r_state == ST_FILL);
  assign w_in_evict  = (r_state == ST_EVICT);

  assign fill_ready  = w_in_fill;
  assign evict_valid = w_in_evict;
  assign busy        = (r_state != ST_IDLE);
  assign fill_done   = r_fill_done;
  assign evict_done  = r_evict_done;
  assign fill_wr     = w_in_fill & fill_valid;
  assign burst_addr  = {r_line, r_beat};

endmodule

// File: rtl/cache_line_data_memory.sv
// cache_line_data_memory
//  Direct-mapped cache data array with multi-word lines and per-byte CPU
//  writes, plus a burst engine for line refill and eviction.
//  Ports:
//   iCLK, iRST                     clock, synchronous active-high reset
//   idx, word_off                  CPU word address
//   cpu_we, cpu_be, cpu_wdata      CPU byte-masked write (ignored while busy)
//   cpu_rdata                      combinational read of mem[idx][word_off]
//   fill_start, fill_idx           start a refill of a line
//   fill_valid, fill_data          refill beats from memory side
//   fill_ready, fill_done          refill handshake / completion pulse
//   evict_start, evict_idx         start an eviction of a line
//   evict_valid, evict_data        eviction beats toward memory side
//   evict_ready, evict_done        eviction handshake / completion pulse
//   busy                           burst engine not idle
module cache_line_data_memory
  import cache_pkg::*;
#(
  parameter int IDX_W      = DEF_IDX_W,
  parameter int WORD_OFF_W = DEF_WORD_OFF_W,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic [IDX_W-1:0]      idx,
  input  logic [WORD_OFF_W-1:0] word_off,
  input  logic                  cpu_we,
  input  logic [DATA_W/8-1:0]   cpu_be,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic                  fill_start,
  input  logic [IDX_W-1:0]      fill_idx,
  input  logic                  fill_valid,
  input  logic [DATA_W-1:0]     fill_data,
  output logic                  fill_ready,
  output logic                  fill_done,
  input  logic                  evict_start,
  input  logic [IDX_W-1:0]      evict_idx,
  output logic                  evict_valid,
  output logic [DATA_W-1:0]     evict_data,
  input  logic                  evict_ready,
  output logic                  evict_done,
  output logic                  busy
);

  localparam int BE_W   = be_w_of(DATA_W);
  localparam int ADDR_W = IDX_W + WORD_OFF_W;
  localparam int DEPTH  = (2 ** IDX_W) * words_of(WORD_OFF_W);

  logic              w_busy;
  logic              w_fill_wr;
  logic [ADDR_W-1:0] w_burst_addr;

  cache_burst_fsm #(
    .IDX_W      (IDX_W),
    .WORD_OFF_W (WORD_OFF_W)
  ) u_burst_fsm (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .fill_start  (fill_start),
    .fill_idx    (fill_idx),
    .fill_valid  (fill_valid),
    .evict_start (evict_start),
    .evict_idx   (evict_idx),
    .evict_ready (evict_ready),
    .fill_ready  (fill_ready),
    .fill_done   (fill_done),
    .evict_valid (evict_valid),
    .evict_done  (evict_done),
    .busy        (w_busy),
    .fill_wr     (w_fill_wr),
    .burst_addr  (w_burst_addr)
  );

  assign busy = w_busy;

  // Single write port shared by refill and CPU. The CPU only writes while
  // the engine is idle and refill only writes while it is busy, so the two
  // sources never collide.
  logic              w_cpu_wr;
  logic [ADDR_W-1:0] w_cpu_addr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [BE_W-1:0]   w_wr_be;
  logic [DATA_W-1:0] w_wr_data;
  logic [DATA_W-1:0] w_cpu_rd;
  logic [DATA_W-1:0] w_evict_rd;

  assign w_cpu_wr   = cpu_we & ~w_busy;
  assign w_cpu_addr = {idx, word_off};
  assign w_wr_addr  = w_fill_wr ? w_burst_addr : w_cpu_addr;
  assign w_wr_data  = w_fill_wr ? fill_data : cpu_wdata;
  assign w_wr_be    = w_fill_wr ? {BE_W{1'b1}} : (w_cpu_wr ? cpu_be : {BE_W{1'b0}});

  // One storage array per byte lane so each lane has its own write enable.
  // Reads are asynchronous: the CPU and eviction paths both need same-cycle data.
  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_lane
      logic [7:0] r_lane [DEPTH];

      always_ff @(posedge iCLK) begin
        if (w_wr_be[gi]) begin
          r_lane[w_wr_addr] <= w_wr_data[gi*8 +: 8];
        end
      end

      assign w_cpu_rd[gi*8 +: 8]   = r_lane[w_cpu_addr];
      assign w_evict_rd[gi*8 +: 8] = r_lane[w_burst_addr];
    end
  endgenerate

  assign cpu_rdata  = w_cpu_rd;
  assign evict_data = w_evict_rd;

endmodule

// File: tb/tb_cache_line_data_memory.sv
module tb_cache_line_data_memory;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic [4:0]  idx = '0;
  logic [1:0]  word_off = '0;
  logic        cpu_we = 1'b0;
  logic [3:0]  cpu_be = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        fill_start = 1'b0;
  logic [4:0]  fill_idx = '0;
  logic        fill_valid = 1'b0;
  logic [31:0] fill_data = '0;
  logic        fill_ready;
  logic        fill_done;
  logic        evict_start = 1'b0;
  logic [4:0]  evict_idx = '0;
  logic        evict_valid;
  logic [31:0] evict_data;
  logic        evict_ready = 1'b0;
  logic        evict_done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  cache_line_data_memory dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .idx         (idx),
    .word_off    (word_off),
    .cpu_we      (cpu_we),
    .cpu_be      (cpu_be),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .fill_start  (fill_start),
    .fill_idx    (fill_idx),
    .fill_valid  (fill_valid),
    .fill_data   (fill_data),
    .fill_ready  (fill_ready),
    .fill_done   (fill_done),
    .evict_start (evict_start),
    .evict_idx   (evict_idx),
    .evict_valid (evict_valid),
    .evict_data  (evict_data),
    .evict_ready (evict_ready),
    .evict_done  (evict_done),
    .busy        (busy)
  );

  always #5 iCLK = ~iCLK;

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    tick();
    tick();
    iRST = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (fill_ready !== 1'b0) begin bad++; $display("FAIL reset_fill_ready got=%b want=0", fill_ready); end
    total++; if (evict_valid !== 1'b0) begin bad++; $display("FAIL reset_evict_valid got=%b want=0", evict_valid); end
    total++; if (fill_done !== 1'b0) begin bad++; $display("FAIL reset_fill_done got=%b want=0", fill_done); end
    total++; if (evict_done !== 1'b0) begin bad++; $display("FAIL reset_evict_done got=%b want=0", evict_done); end
    $display("reset: busy=%b fill_ready=%b evict_valid=%b", busy, fill_ready, evict_valid);
  endtask

  task automatic test_cpu_write();
    idx = 5'd3; word_off = 2'd1; cpu_be = 4'hF; cpu_wdata = 32'hDEADBEEF; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    #1;
    total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL cpu_write got=%h want=deadbeef", cpu_rdata); end
    $display("cpu write idx=3 word=1 data=%h", cpu_rdata);
  endtask

  task automatic test_byte_enable();
    idx = 5'd3; word_off = 2'd1; cpu_be = 4'hF; cpu_wdata = 32'h11223344; cpu_we = 1'b1;
    tick();
    cpu_be = 4'b0101; cpu_wdata = 32'hAABBCCDD;
    #1;
    // Read-before-write: the pending write is not visible yet.
    total++; if (cpu_rdata !== 32'h11223344) begin bad++; $display("FAIL rbw got=%h want=11223344", cpu_rdata); end
    tick();
    cpu_we = 1'b0;
    #1;
    total++; if (cpu_rdata !== 32'h11BB33DD) begin bad++; $display("FAIL byte_en got=%h want=11bb33dd", cpu_rdata); end
    cpu_we = 1'b1; cpu_be = 4'h0; cpu_wdata = 32'hFFFFFFFF;
    tick();
    cpu_we = 1'b0;
    #1;
    total++; if (cpu_rdata !== 32'h11BB33DD) begin bad++; $display("FAIL be_zero got=%h want=11bb33dd", cpu_rdata); end
    $display("byte enables: word=%h", cpu_rdata);
  endtask

  task automatic test_fill_stall();
    fill_idx = 5'd7; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    #1;
    total++; if (fill_ready !== 1'b1) begin bad++; $display("FAIL fill_ready got=%b want=1", fill_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fill_busy got=%b want=1", busy); end
    for (int k = 0; k < 4; k++) begin
      fill_valid = 1'b1; fill_data = 32'hA0 + k;
      tick();
      fill_valid = 1'b0;
      #1;
      if (k < 3) begin
        total++; if (fill_done !== 1'b0) begin bad++; $display("FAIL fill_done_early beat=%0d got=%b want=0", k, fill_done); end
        tick();
        total++; if (fill_done !== 1'b0) begin bad++; $display("FAIL fill_done_stall beat=%0d got=%b want=0", k, fill_done); end
      end
    end
    total++; if (fill_done !== 1'b1) begin bad++; $display("FAIL fill_done got=%b want=1", fill_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fill_busy_done got=%b want=0", busy); end
    tick();
    total++; if (fill_done !== 1'b0) begin bad++; $display("FAIL fill_done_pulse got=%b want=0", fill_done); end
    idx = 5'd7;
    for (int w = 0; w < 4; w++) begin
      word_off = w[1:0];
      #1;
      total++; if (cpu_rdata !== 32'hA0 + w) begin bad++; $display("FAIL fill_word%0d got=%h want=%h", w, cpu_rdata, 32'hA0 + w); end
    end
    $display("fill with stalls idx=7 done");
  endtask

  task automatic test_evict_backpressure();
    int e;
    int c;
    evict_idx = 5'd7; evict_start = 1'b1;
    tick();
    evict_start = 1'b0;
    e = 0;
    c = 0;
    while (e < 4 && c < 20) begin
      evict_ready = (c % 2 == 0);
      #1;
      total++; if (evict_valid !== 1'b1) begin bad++; $display("FAIL evict_valid cyc=%0d got=%b want=1", c, evict_valid); end
      total++; if (evict_data !== 32'hA0 + e) begin bad++; $display("FAIL evict_data cyc=%0d got=%h want=%h", c, evict_data, 32'hA0 + e); end
      total++; if (evict_done !== 1'b0) begin bad++; $display("FAIL evict_done_early cyc=%0d got=%b want=0", c, evict_done); end
      tick();
      if (evict_ready) e++;
      c++;
    end
    total++; if (e !== 4) begin bad++; $display("FAIL evict_timeout got=%0d want=4", e); end
    evict_ready = 1'b0;
    #1;
    total++; if (evict_done !== 1'b1) begin bad++; $display("FAIL evict_done got=%b want=1", evict_done); end
    total++; if (evict_valid !== 1'b0) begin bad++; $display("FAIL evict_valid_done got=%b want=0", evict_valid); end
    tick();
    total++; if (evict_done !== 1'b0) begin bad++; $display("FAIL evict_done_pulse got=%b want=0", evict_done); end
    $display("evict with backpressure idx=7 cycles=%0d", c);
  endtask

  task automatic test_contention();
    // Preload line 9 so an unwanted refill would be visible.
    idx = 5'd9; cpu_be = 4'hF; cpu_we = 1'b1;
    for (int w = 0; w < 4; w++) begin
      word_off = w[1:0]; cpu_wdata = 32'h90000000 + w;
      tick();
    end
    cpu_we = 1'b0;
    fill_start = 1'b1; fill_idx = 5'd9;
    evict_start = 1'b1; evict_idx = 5'd7;
    tick();
    fill_start = 1'b0; evict_start = 1'b0;
    #1;
    total++; if (evict_valid !== 1'b1) begin bad++; $display("FAIL cont_evict got=%b want=1", evict_valid); end
    total++; if (fill_ready !== 1'b0) begin bad++; $display("FAIL cont_fill_ready got=%b want=0", fill_ready); end
    // CPU write and stray refill beats while evicting must not land.
    idx = 5'd7; word_off = 2'd2; cpu_be = 4'hF; cpu_wdata = 32'hFFFFFFFF; cpu_we = 1'b1;
    fill_valid = 1'b1; fill_data = 32'h55;
    evict_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    cpu_we = 1'b0; fill_valid = 1'b0; evict_ready = 1'b0;
    #1;
    total++; if (evict_done !== 1'b1) begin bad++; $display("FAIL cont_evict_done got=%b want=1", evict_done); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_no_fill got=%b want=0", busy); end
    idx = 5'd7; word_off = 2'd2;
    #1;
    total++; if (cpu_rdata !== 32'hA2) begin bad++; $display("FAIL cont_cpu_ignored got=%h want=000000a2", cpu_rdata); end
    idx = 5'd9;
    for (int w = 0; w < 4; w++) begin
      word_off = w[1:0];
      #1;
      total++; if (cpu_rdata !== 32'h90000000 + w) begin bad++; $display("FAIL cont_line9_w%0d got=%h want=%h", w, cpu_rdata, 32'h90000000 + w); end
    end
    $display("contention: evict ran, fill dropped");
  endtask

  task automatic test_reset_mid_fill();
    fill_idx = 5'd9; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fill_valid = 1'b1; fill_data = 32'hB0 + k;
      tick();
    end
    fill_valid = 1'b0;
    iRST = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (fill_done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", fill_done); end
    iRST = 1'b0;
    tick();
    total++; if (fill_done !== 1'b0) begin bad++; $display("FAIL midrst_done_after got=%b want=0", fill_done); end
    idx = 5'd9;
    for (int w = 0; w < 4; w++) begin
      logic [31:0] exp;
      exp = (w < 2) ? (32'hB0 + w) : (32'h90000000 + w);
      word_off = w[1:0];
      #1;
      total++; if (cpu_rdata !== exp) begin bad++; $display("FAIL midrst_w%0d got=%h want=%h", w, cpu_rdata, exp); end
    end
    $display("reset mid-fill idx=9");
  endtask

  task automatic test_back_to_back();
    fill_idx = 5'd10; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fill_valid = 1'b1; fill_data = 32'hC0 + k;
      tick();
      if (k < 3) begin
        total++; if (fill_done !== 1'b0) begin bad++; $display("FAIL b2b_done_early beat=%0d got=%b want=0", k, fill_done); end
      end
    end
    fill_valid = 1'b0;
    total++; if (fill_done !== 1'b1) begin bad++; $display("FAIL b2b_fill_done got=%b want=1", fill_done); end
    // New start accepted in the done cycle.
    evict_idx = 5'd10; evict_start = 1'b1; evict_ready = 1'b0;
    tick();
    evict_start = 1'b0;
    #1;
    total++; if (evict_valid !== 1'b1) begin bad++; $display("FAIL b2b_evict_valid got=%b want=1", evict_valid); end
    total++; if (evict_data !== 32'hC0) begin bad++; $display("FAIL b2b_evict_data got=%h want=000000c0", evict_data); end
    evict_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    evict_ready = 1'b0;
    total++; if (evict_done !== 1'b1) begin bad++; $display("FAIL b2b_evict_done got=%b want=1", evict_done); end
    $display("back-to-back fill->evict idx=10");
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_byte_enable();
    test_fill_stall();
    test_evict_backpressure();
    test_contention();
    test_reset_mid_fill();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
